// File: rtl/aes_inv_round_seq.sv
// One AES inverse cipher round, computed one output column per cycle.
// A round is captured on start, four columns are produced over four cycles,
// then done pulses for one cycle while state_out holds the full result.
module aes_inv_round_seq (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         last,
  input  logic [127:0] state_in,
  input  logic [127:0] key_in,
  output logic [127:0] state_out,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t         fsm, fsm_next;
  logic         capture;
  logic [127:0] data_reg;
  logic [127:0] key_reg;
  logic         last_reg;
  logic [127:0] result_reg;
  logic [1:0]   col;

  logic [7:0]   data_byte [16];
  logic [7:0]   key_byte  [16];
  logic [7:0]   sub_key   [4];
  logic [31:0]  col_word;

  // Multiply by x modulo the AES polynomial 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) multiply, shift-and-add over the bits of b.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, bb;
    p  = 8'h00;
    x  = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ x;
      x  = xtime(x);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; 0 maps to 0 without special casing.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = a;
    for (int i = 0; i < 6; i++) begin
      r = gf_mul(gf_mul(r, r), a);
    end
    return gf_mul(r, r);
  endfunction

  // Inverse S-box: undo the affine map first, then invert in the field.
  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] t;
    t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  // One row of the InvMixColumns circulant {0e,0b,0d,09}.
  function automatic logic [7:0] inv_mix_byte(input logic [7:0] a, input logic [7:0] b,
                                              input logic [7:0] c, input logic [7:0] d);
    return gf_mul(8'h0e, a) ^ gf_mul(8'h0b, b) ^ gf_mul(8'h0d, c) ^ gf_mul(8'h09, d);
  endfunction

  genvar gi;

  generate
    for (gi = 0; gi < 16; gi++) begin : g_unpack
      assign data_byte[gi] = data_reg[127-8*gi -: 8];
      assign key_byte[gi]  = key_reg[127-8*gi -: 8];
    end
  endgenerate

  // Row gi of output column col comes from input column (col - gi) mod 4;
  // the 2-bit subtraction provides the wrap-around.
  generate
    for (gi = 0; gi < 4; gi++) begin : g_row
      logic [1:0] src_col;
      assign src_col     = col - 2'(gi);
      assign sub_key[gi] = inv_sbox(data_byte[{src_col, 2'(gi)}]) ^ key_byte[{col, 2'(gi)}];
    end
  endgenerate

  // Column result: the final round bypasses InvMixColumns.
  always_comb begin
    col_word = {sub_key[0], sub_key[1], sub_key[2], sub_key[3]};
    if (!last_reg) begin
      col_word = {inv_mix_byte(sub_key[0], sub_key[1], sub_key[2], sub_key[3]),
                  inv_mix_byte(sub_key[1], sub_key[2], sub_key[3], sub_key[0]),
                  inv_mix_byte(sub_key[2], sub_key[3], sub_key[0], sub_key[1]),
                  inv_mix_byte(sub_key[3], sub_key[0], sub_key[1], sub_key[2])};
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm <= IDLE;
    else        fsm <= fsm_next;
  end

  // Next-state and status decode; start is honoured only when not busy.
  always_comb begin
    fsm_next = fsm;
    capture  = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (fsm)
      IDLE: begin
        if (start) begin
          capture  = 1'b1;
          fsm_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (col == 2'd3) fsm_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          capture  = 1'b1;
          fsm_next = RUN;
        end else begin
          fsm_next = IDLE;
        end
      end
      default: fsm_next = IDLE;
    endcase
  end

  // Operand capture, column counter and column-wise result writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg   <= 128'h0;
      key_reg    <= 128'h0;
      last_reg   <= 1'b0;
      col        <= 2'd0;
      result_reg <= 128'h0;
    end else if (capture) begin
      data_reg <= state_in;
      key_reg  <= key_in;
      last_reg <= last;
      col      <= 2'd0;
    end else if (fsm == RUN) begin
      col <= col + 2'd1;
      case (col)
        2'd0:    result_reg[127:96] <= col_word;
        2'd1:    result_reg[95:64]  <= col_word;
        2'd2:    result_reg[63:32]  <= col_word;
        default: result_reg[31:0]   <= col_word;
      endcase
    end
  end

  assign state_out = result_reg;

endmodule

// File: tb/tb_aes_inv_round_seq.sv
// Self-checking bench for aes_inv_round_seq against a table-driven
// reference round built from the forward S-box and field arithmetic.
module tb_aes_inv_round_seq;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         last = 1'b0;
  logic [127:0] state_in = 128'h0;
  logic [127:0] key_in = 128'h0;
  logic [127:0] state_out;
  logic         busy;
  logic         done;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] isb [256];

  always #5 clk = ~clk;

  aes_inv_round_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .last(last),
    .state_in(state_in), .key_in(key_in),
    .state_out(state_out), .busy(busy), .done(done)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    while (y != 0) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  // Forward S-box by brute-force inverse plus affine map, then invert the table.
  task automatic build_tables();
    logic [7:0] inv, fwd, xv;
    for (int x = 0; x < 256; x++) begin
      xv  = 8'(x);
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (xv != 0 && gmul(xv, 8'(y)) == 8'h01) inv = 8'(y);
      fwd = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      isb[fwd] = xv;
    end
  endtask

  function automatic logic [7:0] coef(input int d);
    case (d)
      0: return 8'h0e;
      1: return 8'h0b;
      2: return 8'h0d;
      default: return 8'h09;
    endcase
  endfunction

  // Reference inverse round on a byte array (byte 4c+r = row r, column c).
  function automatic logic [127:0] model_round(input logic [127:0] s, input logic [127:0] k, input logic l);
    logic [7:0] sb [16];
    logic [7:0] kb [16];
    logic [7:0] a  [16];
    logic [127:0] ss, kk, res;
    logic [7:0] o;
    ss = s; kk = k; res = 128'h0;
    for (int n = 0; n < 16; n++) begin
      sb[n] = ss[127:120]; kb[n] = kk[127:120];
      ss = ss << 8; kk = kk << 8;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        a[4*c+r] = isb[sb[4*((c - r + 4) % 4) + r]] ^ kb[4*c+r];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        if (l) o = a[4*c+r];
        else begin
          o = 8'h00;
          for (int j = 0; j < 4; j++) o = o ^ gmul(coef((j - r + 4) % 4), a[4*c+j]);
        end
        res = {res[119:0], o};
      end
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Issue one round and watch for done; lat = negedges after the capture edge.
  task automatic do_round(input logic [127:0] s, input logic [127:0] k, input logic l,
                          input bit scramble, input bit poke,
                          output logic [127:0] res, output int lat);
    @(negedge clk);
    state_in = s; key_in = k; last = l; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    lat = -1; res = 128'h0;
    for (int i = 0; i < 12; i++) begin
      start = 1'b0;
      if (done) begin
        lat = i; res = state_out;
        break;
      end
      if (scramble) begin
        state_in = rnd128(); key_in = rnd128(); last = 1'($urandom_range(0, 1));
      end
      if (poke) begin
        start = 1'b1; state_in = rnd128(); key_in = rnd128();
      end
      @(negedge clk);
    end
    start = 1'b0;
    $display("[TB] round last=%0d in=%h key=%h out=%h lat=%0d", l, s, k, res, lat);
  endtask

  task automatic test_reset();
    start = 1'b1;
    repeat (2) @(negedge clk);
    tests_run += 3;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", done); end
    if (state_out !== 128'h0) begin tests_failed++; $display("FAIL reset_out: got %h want 0", state_out); end
    rst_n = 1'b1; start = 1'b0;
  endtask

  task automatic test_vectors();
    logic [127:0] vs [4] = '{128'h7ad5fda789ef4e272bca100b3d9ff59f, 128'h6353e08c0960e104cd70b751bacad0e7,
                             {16{8'h63}}, 128'h0};
    logic [127:0] ks [4] = '{128'h549932d1f08557681093ed9cbe2c974e, 128'h000102030405060708090a0b0c0d0e0f,
                             128'h0, 128'h0};
    logic         ls [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [127:0] ex [4] = '{128'h54d990a16ba09ab596bbf40ea111702f, 128'h00112233445566778899aabbccddeeff,
                             128'h0, {16{8'h52}}};
    logic [127:0] res;
    int lat;
    for (int t = 0; t < 4; t++) begin
      do_round(vs[t], ks[t], ls[t], 1'b0, 1'b0, res, lat);
      tests_run += 2;
      if (res !== ex[t]) begin tests_failed++; $display("FAIL vector%0d: got %h want %h", t, res, ex[t]); end
      if (lat !== 4) begin tests_failed++; $display("FAIL vector%0d_latency: got %0d want 4", t, lat); end
    end
  endtask

  task automatic test_random();
    logic [127:0] s, k, exp, res;
    logic l;
    int lat;
    for (int t = 0; t < 16; t++) begin
      s = rnd128(); k = rnd128(); l = 1'($urandom_range(0, 1));
      exp = model_round(s, k, l);
      do_round(s, k, l, 1'b0, 1'b0, res, lat);
      tests_run += 2;
      if (res !== exp) begin tests_failed++; $display("FAIL random%0d: got %h want %h", t, res, exp); end
      if (lat !== 4) begin tests_failed++; $display("FAIL random%0d_latency: got %0d want 4", t, lat); end
      repeat (3) @(negedge clk);
      tests_run += 2;
      if (state_out !== exp) begin tests_failed++; $display("FAIL random%0d_hold: got %h want %h", t, state_out, exp); end
      if (busy !== 1'b0) begin tests_failed++; $display("FAIL random%0d_idle: got busy=%b want 0", t, busy); end
    end
  endtask

  task automatic test_busy_ignore();
    logic [127:0] s, k, exp, res;
    int lat;
    int seen;
    s = rnd128(); k = rnd128();
    exp = model_round(s, k, 1'b0);
    do_round(s, k, 1'b0, 1'b0, 1'b1, res, lat);
    tests_run += 2;
    if (res !== exp) begin tests_failed++; $display("FAIL busy_ignore_result: got %h want %h", res, exp); end
    if (lat !== 4) begin tests_failed++; $display("FAIL busy_ignore_latency: got %0d want 4", lat); end
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy || done) seen++;
    end
    tests_run++;
    if (seen !== 0) begin tests_failed++; $display("FAIL busy_ignore_queued: got %0d active cycles want 0", seen); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] sa, ka, sb, kb, ea, eb, oa, ob;
    int ta, tb, nd;
    sa = rnd128(); ka = rnd128(); sb = rnd128(); kb = rnd128();
    ea = model_round(sa, ka, 1'b0);
    eb = model_round(sb, kb, 1'b1);
    @(negedge clk);
    state_in = sa; key_in = ka; last = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    state_in = sb; key_in = kb; last = 1'b1;
    ta = -1; tb = -1; nd = 0; oa = 128'h0; ob = 128'h0;
    for (int i = 0; i < 16; i++) begin
      if (done) begin
        if (nd == 0) begin ta = i; oa = state_out; end
        else begin tb = i; ob = state_out; start = 1'b0; end
        nd++;
      end
      if (nd == 2) break;
      @(negedge clk);
    end
    start = 1'b0;
    $display("[TB] back_to_back doneA@%0d outA=%h doneB@%0d outB=%h", ta, oa, tb, ob);
    @(negedge clk);
    tests_run += 5;
    if (ta !== 4) begin tests_failed++; $display("FAIL b2b_first_latency: got %0d want 4", ta); end
    if (tb !== 9) begin tests_failed++; $display("FAIL b2b_second_latency: got %0d want 9", tb); end
    if (oa !== ea) begin tests_failed++; $display("FAIL b2b_first_result: got %h want %h", oa, ea); end
    if (ob !== eb) begin tests_failed++; $display("FAIL b2b_second_result: got %h want %h", ob, eb); end
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL b2b_no_third: got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] s, k, exp, res;
    int lat, seen;
    @(negedge clk);
    state_in = rnd128(); key_in = rnd128(); last = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0; start = 1'b1;
    #1;
    tests_run += 3;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL midreset_busy: got %b want 0", busy); end
    if (done !== 1'b0) begin tests_failed++; $display("FAIL midreset_done: got %b want 0", done); end
    if (state_out !== 128'h0) begin tests_failed++; $display("FAIL midreset_out: got %h want 0", state_out); end
    repeat (2) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL midreset_start_ignored: got busy=%b want 0", busy); end
    rst_n = 1'b1; start = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) seen++;
    end
    tests_run++;
    if (seen !== 0) begin tests_failed++; $display("FAIL midreset_no_done: got %0d pulses want 0", seen); end
    s = rnd128(); k = rnd128();
    exp = model_round(s, k, 1'b0);
    do_round(s, k, 1'b0, 1'b0, 1'b0, res, lat);
    tests_run += 2;
    if (res !== exp) begin tests_failed++; $display("FAIL midreset_restart: got %h want %h", res, exp); end
    if (lat !== 4) begin tests_failed++; $display("FAIL midreset_restart_latency: got %0d want 4", lat); end
  endtask

  task automatic test_input_change();
    logic [127:0] s, k, exp, res;
    logic l;
    int lat;
    for (int t = 0; t < 4; t++) begin
      s = rnd128(); k = rnd128(); l = 1'($urandom_range(0, 1));
      exp = model_round(s, k, l);
      do_round(s, k, l, 1'b1, 1'b0, res, lat);
      tests_run += 2;
      if (res !== exp) begin tests_failed++; $display("FAIL input_change%0d: got %h want %h", t, res, exp); end
      if (lat !== 4) begin tests_failed++; $display("FAIL input_change%0d_latency: got %0d want 4", t, lat); end
    end
  endtask

  initial begin
    build_tables();
    test_reset();
    test_vectors();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_input_change();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_inv_round_seq.md
AES_INV_ROUND_SEQ -- requirements
Module: aes_inv_round_seq

Interface
REQ-001 Port clk, input, 1 bit: single clock; all state updates occur on its rising edge.
REQ-002 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 Port start, input, 1 bit: request one inverse round; sampled only when busy=0.
REQ-004 Port last, input, 1 bit: 1 = final inverse round, which skips InvMixColumns; sampled with start.
REQ-005 Port state_in, input, 128 bits: ciphertext-side state; byte n = bits [127-8n -: 8]; column-major, so byte 4c+r = row r, column c.
REQ-006 Port key_in, input, 128 bits: round key, same byte order; sampled with start.
REQ-007 Port state_out, output, 128 bits: result of the round, same byte order.
REQ-008 Port busy, output, 1 bit: round in progress.
REQ-009 Port done, output, 1 bit: one-cycle pulse; state_out is valid in that cycle.

Function
REQ-010 The block SHALL compute, in order: InvShiftRows, InvSubBytes, AddRoundKey(key_in), then InvMixColumns unless last=1 (FIPS-197 inverse cipher round).
REQ-011 InvShiftRows: output row r, column c SHALL equal input row r, column (c-r) mod 4.
REQ-012 InvSubBytes SHALL be computed arithmetically: inverse affine transform, then GF(2^8) multiplicative inverse modulo 0x11B, with inverse(0x00)=0x00; no 256-entry table.
REQ-013 InvMixColumns SHALL multiply each column by the circulant matrix {0e,0b,0d,09} over GF(2^8) modulo 0x11B.
REQ-014 FSM states SHALL be IDLE, RUN and DONE.
REQ-015 In IDLE, start=1 at edge E0 SHALL capture state_in, key_in and last into internal registers, clear column counter col to 0, and move to RUN.
REQ-016 In RUN, edges E1..E4 SHALL each compute one full output column (col = 0..3) from the captured registers and write it into the result register; col increments modulo 4.
REQ-017 At edge E4 the FSM SHALL go to DONE; busy=1 from after E0 through E4 and 0 otherwise.
REQ-018 In DONE, done=1 for exactly one cycle (E4 to E5); the FSM then returns to IDLE.
REQ-019 Fixed latency: done SHALL be high 4 cycles after the start-sampling edge.
REQ-020 state_out SHALL be driven directly from the result register.
REQ-021 state_out SHALL hold the last completed result until the next round's column writes; partially written columns may be visible while busy=1.
REQ-022 start while busy=1 SHALL be ignored; it is neither queued nor able to corrupt the captured registers.
REQ-023 start=1 in the DONE cycle SHALL be accepted (busy=0 there), giving back-to-back rounds every 5 cycles.
REQ-024 Changes to state_in, key_in or last after E0 SHALL NOT affect the running round.

Reset
REQ-025 rst_n=0 SHALL immediately force: FSM to IDLE, col to 0, busy=0, done=0, state_out=128'h0, captured registers to 0.
REQ-026 Reset asserted mid-round SHALL abort the round with no done pulse; the first start after reset release SHALL behave as in REQ-015.
REQ-027 start SHALL be ignored while rst_n=0.

Verification
REQ-028 Round vector (last=0): state_in=7ad5fda789ef4e272bca100b3d9ff59f, key_in=549932d1f08557681093ed9cbe2c974e -> 4 cycles later done=1 and state_out=54d990a16ba09ab596bbf40ea111702f.
REQ-029 Final round (last=1): state_in=6353e08c0960e104cd70b751bacad0e7, key_in=000102030405060708090a0b0c0d0e0f -> state_out=00112233445566778899aabbccddeeff.
REQ-030 S-box spot checks: with last=1 and key_in=0, state_in all 0x63 -> state_out all 0x00; state_in all 0x00 -> state_out all 0x52.
REQ-031 Back-to-back: start held high across two rounds with different inputs -> done pulses 5 cycles apart, each with the correct result; start pulses during busy are ignored.
REQ-032 Reset at E2 of a round -> busy=0, done=0 and state_out=0 at once, no done afterward; a new start then gives the correct result at E4.
REQ-033 Input change: state_in and key_in are randomized on every cycle after E0 -> the result equals that computed from the values captured at E0.
